ofm_reader: RTL and testbench

Read-side engine for the OFM SRAM, the counterpart to the systolic-array write path.
- On `start`, reads a contiguous range of OFM rows. Each row holds SYS_WIDTH x MAC_OUT_BIT accumulators.
- Requantizes each accumulator to signed 8 bit: arithmetic shift, optional ReLU, saturation.
- Packs the results into 32-bit words and streams them to the DMA/bus side over a valid/ready handshake.
- Owns the OFM SRAM port while busy. Never writes.

---
 rtl/TPU_def.sv | 27 ++
 rtl/ofm_requant.sv | 42 ++++
 rtl/ofm_reader.sv | 221 ++++++++++++++++++++++
 tb/tb_ofm_reader.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/TPU_def.sv
// -----------------------------------------------------------------------------
// TPU_def
// Shared definitions for the OFM read path.
//   SYS_WIDTH          accumulators per OFM row (multiple of ELEMS_PER_WORD)
//   MAC_OUT_BIT        accumulator width
//   OFM_SRAM_ADDR_BIT  OFM SRAM address width
//   OUT_W              requantized element width
//   ELEMS_PER_WORD     requantized elements packed into one 32-bit word
//   ofm_rd_state_t     read-engine FSM states
// -----------------------------------------------------------------------------
package TPU_def;

    localparam int SYS_WIDTH         = 8;
    localparam int MAC_OUT_BIT       = 24;
    localparam int OFM_SRAM_ADDR_BIT = 9;
    localparam int OUT_W             = 8;
    localparam int ELEMS_PER_WORD    = 4;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        OUT,
        FIN
    } ofm_rd_state_t;

endpackage

// File: rtl/ofm_requant.sv
// -----------------------------------------------------------------------------
// ofm_requant
// Combinational requantizer for one accumulator: arithmetic right shift,
// optional ReLU, then saturation to a signed OUT_W-bit value.
//   acc      in   MAC_OUT_BIT  signed accumulator
//   shift    in   5            arithmetic right-shift amount
//   relu_en  in   1            clamp negative results to zero
//   q        out  OUT_W        saturated two's-complement result
// -----------------------------------------------------------------------------
module ofm_requant #(
    parameter int MAC_OUT_BIT = TPU_def::MAC_OUT_BIT,
    parameter int OUT_W       = TPU_def::OUT_W
) (
    input  logic signed [MAC_OUT_BIT-1:0] acc,
    input  logic        [4:0]             shift,
    input  logic                          relu_en,
    output logic        [OUT_W-1:0]       q
);

    localparam logic signed [MAC_OUT_BIT-1:0] SAT_MAX = MAC_OUT_BIT'((1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [MAC_OUT_BIT-1:0] SAT_MIN = MAC_OUT_BIT'(-(1 <<< (OUT_W - 1)));

    logic signed [MAC_OUT_BIT-1:0] shifted;

    // NOTE: combinational blocks use blocking '=' so each statement sees the
    // value produced by the one before it within the same evaluation.
    always_comb begin
        // Shift amounts at or beyond the accumulator width leave only sign bits.
        shifted = acc >>> shift;
        if (relu_en && shifted[MAC_OUT_BIT-1]) begin
            shifted = '0;
        end
        if (shifted > SAT_MAX) begin
            q = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            q = SAT_MIN[OUT_W-1:0];
        end else begin
            q = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/ofm_reader.sv
// -----------------------------------------------------------------------------
// ofm_reader
// Reads a contiguous range of OFM SRAM rows, requantizes every accumulator to
// a signed byte and streams the bytes, four per 32-bit word, over valid/ready.
// Owns the SRAM port while busy and never writes it.
//   clk, rst    in   system clock (rising edge), async active-high reset
//   start       in   one-cycle start pulse, honoured only in IDLE
//   base_addr   in   ADDR_W    first row address (sampled on start)
//   row_count   in   ADDR_W+1  number of rows (sampled on start)
//   shift       in   5         requant shift (sampled on start)
//   relu_en     in   1         requant ReLU enable (sampled on start)
//   busy        out  1         job in progress
//   done        out  1         one-cycle completion pulse
//   sram_a      out  ADDR_W    SRAM row address
//   sram_cs     out  1         SRAM chip select
//   sram_oe     out  1         SRAM output enable
//   sram_web    out  SYS_WIDTH SRAM write enables (active low, always off)
//   sram_do     in   SYS_WIDTH x MAC_OUT_BIT  SRAM read data, element 0 = col 0
//   out_data    out  32        packed word, element k in bits [8k+7:8k]
//   out_valid   out  1         out_data valid
//   out_ready   in   1         consumer ready
// -----------------------------------------------------------------------------
module ofm_reader #(
    parameter int SYS_WIDTH   = TPU_def::SYS_WIDTH,
    parameter int MAC_OUT_BIT = TPU_def::MAC_OUT_BIT,
    parameter int ADDR_W      = TPU_def::OFM_SRAM_ADDR_BIT,
    parameter int OUT_W       = TPU_def::OUT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic [ADDR_W:0]        row_count,
    input  logic [4:0]             shift,
    input  logic                   relu_en,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      sram_a,
    output logic                   sram_cs,
    output logic                   sram_oe,
    output logic [SYS_WIDTH-1:0]   sram_web,
    input  logic [MAC_OUT_BIT-1:0] sram_do [SYS_WIDTH],
    output logic [31:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready
);

    import TPU_def::*;

    localparam int WORD_W    = ELEMS_PER_WORD * OUT_W;
    localparam int WORDS     = SYS_WIDTH / ELEMS_PER_WORD;
    localparam int WIDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS - 1);

    ofm_rd_state_t state, state_nxt;

    // Job configuration, frozen at start so the inputs may change while busy.
    logic [ADDR_W-1:0]      cfg_base;
    logic [ADDR_W:0]        cfg_rows;
    logic [4:0]             cfg_shift;
    logic                   cfg_relu;

    logic [ADDR_W:0]        row_idx;
    logic [ADDR_W:0]        row_nxt;
    logic [WIDX_W-1:0]      word_idx;
    logic                   last_word;
    logic                   more_rows;

    logic [MAC_OUT_BIT-1:0]     row_buf [SYS_WIDTH];
    logic [SYS_WIDTH*OUT_W-1:0] q_flat;
    logic [WORD_W-1:0]          word_data;

    assign row_nxt   = row_idx + (ADDR_W + 1)'(1);
    assign last_word = (word_idx == LAST_WORD);
    assign more_rows = (row_nxt < cfg_rows);
    assign sram_web  = '1;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking '<=' so every flop samples the
    // values from before the clock edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so that
    // no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    // An empty job skips the SRAM entirely and just signals done.
                    state_nxt = (row_count != '0) ? RD : FIN;
                end
            end
            RD:  state_nxt = CAP;
            CAP: state_nxt = OUT;
            OUT: begin
                if (out_ready && last_word) begin
                    state_nxt = more_rows ? RD : FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (Moore, decoded from the registered state)
    // -------------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        out_valid = 1'b0;
        sram_cs   = 1'b0;
        sram_oe   = 1'b0;
        sram_a    = '0;
        out_data  = '0;
        case (state)
            RD: begin
                busy    = 1'b1;
                sram_cs = 1'b1;
                sram_oe = 1'b1;
                // Wraps modulo 2^ADDR_W by truncation.
                sram_a  = cfg_base + row_idx[ADDR_W-1:0];
            end
            CAP: busy = 1'b1;
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = word_data;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: config capture, row/word counters, row buffer
    // -------------------------------------------------------------------------
    // NOTE: the row buffer is an array of plain flops and is cleared on reset
    // so no accumulator from an aborted job survives into the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_base  <= '0;
            cfg_rows  <= '0;
            cfg_shift <= '0;
            cfg_relu  <= 1'b0;
            row_idx   <= '0;
            word_idx  <= '0;
            for (int i = 0; i < SYS_WIDTH; i++) begin
                row_buf[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start && row_count != '0) begin
                        cfg_base  <= base_addr;
                        cfg_rows  <= row_count;
                        cfg_shift <= shift;
                        cfg_relu  <= relu_en;
                        row_idx   <= '0;
                    end
                end
                CAP: begin
                    // sram_do is valid only in the cycle after RD.
                    for (int i = 0; i < SYS_WIDTH; i++) begin
                        row_buf[i] <= sram_do[i];
                    end
                    word_idx <= '0;
                end
                OUT: begin
                    // Counters move only on a handshake, which keeps out_data
                    // stable for as long as the consumer stalls.
                    if (out_ready) begin
                        if (!last_word) begin
                            word_idx <= word_idx + WIDX_W'(1);
                        end else if (more_rows) begin
                            row_idx <= row_nxt;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Requantization of the whole row buffer and word selection
    // -------------------------------------------------------------------------
    for (genvar g = 0; g < SYS_WIDTH; g++) begin : g_requant
        ofm_requant #(
            .MAC_OUT_BIT (MAC_OUT_BIT),
            .OUT_W       (OUT_W)
        ) u_requant (
            .acc     (row_buf[g]),
            .shift   (cfg_shift),
            .relu_en (cfg_relu),
            .q       (q_flat[g*OUT_W +: OUT_W])
        );
    end

    always_comb begin
        word_data = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (word_idx == WIDX_W'(w)) begin
                word_data = q_flat[w*WORD_W +: WORD_W];
            end
        end
    end

endmodule

// File: tb/tb_ofm_reader.sv
// -----------------------------------------------------------------------------
// tb_ofm_reader
// Directed bench for ofm_reader. A behavioural synchronous-read SRAM feeds the
// DUT; expected words are queued by the stimulus and consumed by a monitor
// that compares every accepted output word, checks that stalled words hold,
// and logs every SRAM read address.
// -----------------------------------------------------------------------------
module tb_ofm_reader;

    import TPU_def::*;

    localparam int AW = OFM_SRAM_ADDR_BIT;
    localparam int RW = AW + 1;
    localparam int SW = SYS_WIDTH;
    localparam int MW = MAC_OUT_BIT;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [RW-1:0] row_count = '0;
    logic [4:0]    shift = '0;
    logic          relu_en = 1'b0;
    logic          busy, done;
    logic [AW-1:0] sram_a;
    logic          sram_cs, sram_oe;
    logic [SW-1:0] sram_web;
    logic [MW-1:0] sram_do [SW];
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;

    logic [MW-1:0] mem [2**AW][SW];

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard: stimulus writes exp_wr, monitor advances exp_rd.
    logic [31:0] exp_mem [64];
    int exp_wr = 0;
    int exp_rd = 0;

    // SRAM read address log, written by the monitor only.
    logic [AW-1:0] rd_log [256];
    int rd_cnt = 0;

    logic        stall_pend = 1'b0;
    logic [31:0] held = '0;

    ofm_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .row_count (row_count),
        .shift     (shift),
        .relu_en   (relu_en),
        .busy      (busy),
        .done      (done),
        .sram_a    (sram_a),
        .sram_cs   (sram_cs),
        .sram_oe   (sram_oe),
        .sram_web  (sram_web),
        .sram_do   (sram_do),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Synchronous-read SRAM; data outside the cycle after a read is poisoned.
    always @(posedge clk) begin
        for (int i = 0; i < SW; i++) begin
            sram_do[i] <= (sram_cs && sram_oe) ? mem[sram_a][i] : 24'hA5A5A5;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge, where inputs and outputs are settled
    // for the coming rising edge.
    always @(negedge clk) begin
        if (sram_cs) begin
            check("sram_oe_with_cs", sram_oe, 1);
            check("sram_web", sram_web, {SW{1'b1}});
            if (rd_cnt < 256) rd_log[rd_cnt] = sram_a;
            rd_cnt++;
        end
        if (stall_pend && out_valid) begin
            check("stall_hold", out_data, held);
        end
        if (out_valid && out_ready) begin
            if (exp_rd == exp_wr) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got 0x%08h, expected no word", out_data);
            end else begin
                check("out_word", out_data, exp_mem[exp_rd % 64]);
                exp_rd++;
            end
        end
        stall_pend = out_valid && !out_ready;
        held       = out_data;
    end

    task automatic set_row(input int a, input int v0, input int v1, input int v2, input int v3,
                           input int v4, input int v5, input int v6, input int v7);
        int v [8];
        v = '{v0, v1, v2, v3, v4, v5, v6, v7};
        for (int i = 0; i < SW; i++) begin
            mem[a][i] = MW'(v[i]);
        end
    endtask

    task automatic expect_word(input logic [31:0] w);
        exp_mem[exp_wr % 64] = w;
        exp_wr++;
    endtask

    // Issues one job and waits (bounded) for done. lat counts falling edges
    // after the start-accepting edge up to the one showing done; -1 on timeout.
    task automatic run_job(input int base, input int rows, input int sh, input int relu,
                           input logic [3:0] pat, input bit restart,
                           output int lat, output int busy_n, output int cs_n);
        lat    = -1;
        busy_n = 0;
        cs_n   = 0;
        @(posedge clk); #1;
        base_addr = AW'(base);
        row_count = RW'(rows);
        shift     = 5'(sh);
        relu_en   = 1'(relu);
        start     = 1'b1;
        out_ready = pat[0];
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = ~base_addr;
        row_count = RW'(7);
        shift     = shift ^ 5'h15;
        relu_en   = ~relu_en;
        out_ready = pat[1];
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            busy_n += int'(busy);
            cs_n   += int'(sram_cs);
            if (done) begin
                lat = cyc;
                break;
            end
            @(posedge clk); #1;
            out_ready = pat[(cyc + 1) % 4];
            if (restart && cyc == 2) begin
                start     = 1'b1;
                base_addr = AW'(300);
                row_count = RW'(1);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        check("words_outstanding", 32'(exp_wr - exp_rd), 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
    endtask

    int lat, busy_n, cs_n, rd0;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_sram_cs", sram_cs, 0);
        check("rst_sram_oe", sram_oe, 0);
        check("rst_sram_a", sram_a, 0);
        check("rst_out_data", out_data, 0);
        check("rst_sram_web", sram_web, {SW{1'b1}});
        @(posedge clk); #1;
        rst = 1'b0;

        // ---------------- basic read ----------------
        set_row(5, 1, 2, 3, 4, 5, 6, 7, 8);
        expect_word(32'h04030201);
        expect_word(32'h08070605);
        rd0 = rd_cnt;
        run_job(5, 1, 0, 0, 4'b1111, 1'b0, lat, busy_n, cs_n);
        check("basic_latency", 32'(lat), 5);
        check("basic_busy_cycles", 32'(busy_n), 4);
        check("basic_reads", 32'(cs_n), 1);
        check("basic_addr", rd_log[rd0], 5);

        // ---------------- saturation, relu off / on ----------------
        set_row(10, -1000, 1000, -3, 32'h7FFFFF, 256, -129, 127, -128);
        expect_word(32'h7FFD7F80);
        expect_word(32'h807F807F);
        run_job(10, 1, 0, 0, 4'b1111, 1'b0, lat, busy_n, cs_n);
        check("sat_latency", 32'(lat), 5);
        expect_word(32'h7F007F00);
        expect_word(32'h007F007F);
        run_job(10, 1, 0, 1, 4'b1111, 1'b0, lat, busy_n, cs_n);
        check("relu_latency", 32'(lat), 5);

        // ---------------- shift ----------------
        set_row(20, 32'h000400, -512, 32'h7FFFFF, -1, 32'h008000, 32'h007F80, -32768, 300);
        expect_word(32'hFF7FFE04);
        expect_word(32'h01807F7F);
        run_job(20, 1, 8, 0, 4'b1111, 1'b0, lat, busy_n, cs_n);
        check("shift8_latency", 32'(lat), 5);
        set_row(21, -512, 2032, 2048, -2048, -2064, 15, -1, 256);
        expect_word(32'h807F7FE0);
        expect_word(32'h10FF0080);
        run_job(21, 1, 4, 0, 4'b1111, 1'b0, lat, busy_n, cs_n);
        check("shift4_latency", 32'(lat), 5);
        set_row(22, -1, -8388608, 8388607, 1, -5, 5, 0, -100);
        expect_word(32'h0000FFFF);
        expect_word(32'hFF0000FF);
        run_job(22, 1, 31, 0, 4'b1111, 1'b0, lat, busy_n, cs_n);
        check("shift31_latency", 32'(lat), 5);

        // ---------------- backpressure, 3 rows, ready 1-0-0-1 ----------------
        set_row(100, 'h10, 'h11, 'h12, 'h13, 'h14, 'h15, 'h16, 'h17);
        set_row(101, 'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27);
        set_row(102, 'h30, 'h31, 'h32, 'h33, 'h34, 'h35, 'h36, 'h37);
        expect_word(32'h13121110);
        expect_word(32'h17161514);
        expect_word(32'h23222120);
        expect_word(32'h27262524);
        expect_word(32'h33323130);
        expect_word(32'h37363534);
        rd0 = rd_cnt;
        run_job(100, 3, 0, 0, 4'b1001, 1'b0, lat, busy_n, cs_n);
        check("bp_done_seen", lat > 0, 1);
        check("bp_reads", 32'(cs_n), 3);
        check("bp_addr0", rd_log[rd0], 100);
        check("bp_addr1", rd_log[rd0 + 1], 101);
        check("bp_addr2", rd_log[rd0 + 2], 102);

        // ---------------- zero rows ----------------
        rd0 = rd_cnt;
        run_job(40, 0, 0, 0, 4'b1111, 1'b0, lat, busy_n, cs_n);
        check("zero_latency", 32'(lat), 1);
        check("zero_busy_cycles", 32'(busy_n), 0);
        check("zero_reads", 32'(rd_cnt - rd0), 0);

        // ---------------- address wrap ----------------
        set_row(511, 'h40, 'h41, 'h42, 'h43, 'h44, 'h45, 'h46, 'h47);
        set_row(0, 'h50, 'h51, 'h52, 'h53, 'h54, 'h55, 'h56, 'h57);
        expect_word(32'h43424140);
        expect_word(32'h47464544);
        expect_word(32'h53525150);
        expect_word(32'h57565554);
        rd0 = rd_cnt;
        run_job(511, 2, 0, 0, 4'b1111, 1'b0, lat, busy_n, cs_n);
        check("wrap_latency", 32'(lat), 9);
        check("wrap_reads", 32'(cs_n), 2);
        check("wrap_addr0", rd_log[rd0], 511);
        check("wrap_addr1", rd_log[rd0 + 1], 0);

        // ---------------- start while busy is ignored ----------------
        expect_word(32'h04030201);
        expect_word(32'h08070605);
        rd0 = rd_cnt;
        run_job(5, 1, 0, 0, 4'b1111, 1'b1, lat, busy_n, cs_n);
        check("restart_latency", 32'(lat), 5);
        check("restart_reads", 32'(cs_n), 1);
        busy_n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            busy_n += int'(busy);
        end
        check("restart_no_second_job", 32'(busy_n), 0);
        check("restart_total_reads", 32'(rd_cnt - rd0), 1);

        // ---------------- reset mid-stream ----------------
        @(posedge clk); #1;
        base_addr = AW'(5);
        row_count = RW'(1);
        shift     = '0;
        relu_en   = 1'b0;
        start     = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check("midrst_valid_before", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_sram_cs", sram_cs, 0);
        check("midrst_out_data", out_data, 0);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        expect_word(32'h04030201);
        expect_word(32'h08070605);
        run_job(5, 1, 0, 0, 4'b1111, 1'b0, lat, busy_n, cs_n);
        check("post_rst_latency", 32'(lat), 5);
        check("post_rst_reads", 32'(cs_n), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
